// File: rtl/ysyx_23060075_mem_arbiter.sv
// Shares the single data-memory port between instruction fetch (IFU) and
// load/store (LSU). One transaction is outstanding at a time. The request is
// captured into registers, presented to memory, and the response is steered
// back to whichever requester owns the transaction.
//
// Build option: define YSYX_23060075_ARB_RR_EN to use round-robin arbitration
// when both requesters tie. Without it, the LSU always wins over the IFU.
//
// state | meaning
// IDLE  | no transaction in flight; arbitrate and accept one request
// REQ   | captured request driven to memory, waiting for mem_req_ready
// RSP   | memory accepted the request, waiting for mem_rsp_valid
module ysyx_23060075_mem_arbiter #(
  parameter int ISA_WIDTH  = 32,
  parameter int MASK_WIDTH = ISA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ISA_WIDTH-1:0]  ifu_addr,
  output logic                  ifu_rsp_valid,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ISA_WIDTH-1:0]  lsu_addr,
  input  logic [ISA_WIDTH-1:0]  lsu_w_data,
  input  logic [MASK_WIDTH-1:0] lsu_mask,
  input  logic                  lsu_w_en,
  output logic                  lsu_rsp_valid,
  output logic [ISA_WIDTH-1:0]  rsp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ISA_WIDTH-1:0]  mem_addr,
  output logic [ISA_WIDTH-1:0]  mem_w_data,
  output logic [MASK_WIDTH-1:0] mem_mask,
  output logic                  mem_r_en,
  output logic                  mem_w_en,
  input  logic                  mem_rsp_valid,
  input  logic [ISA_WIDTH-1:0]  mem_rsp_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic [ISA_WIDTH-1:0]  addr_q, addr_d;
  logic [ISA_WIDTH-1:0]  w_data_q, w_data_d;
  logic [MASK_WIDTH-1:0] mask_q, mask_d;
  logic                  r_en_q, r_en_d;
  logic                  w_en_q, w_en_d;

  logic grant_ifu;
  logic grant_lsu;
  logic arb_open;

  // Requests are only accepted in IDLE and never while reset is held.
  assign arb_open = (state_q == IDLE) && !rst;

`ifdef YSYX_23060075_ARB_RR_EN
  logic last_grant_q, last_grant_d;  // 1 = LSU won the last handshake

  // Round-robin: on a tie the requester not granted last time wins.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (arb_open) begin
      if (lsu_req_valid && ifu_req_valid) begin
        grant_ifu = last_grant_q;
        grant_lsu = !last_grant_q;
      end else begin
        grant_ifu = ifu_req_valid;
        grant_lsu = lsu_req_valid;
      end
    end
  end

  // Track the most recent winner for the next tie.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_lsu) begin
      last_grant_d = 1'b1;
    end else if (grant_ifu) begin
      last_grant_d = 1'b0;
    end
  end

  // Last-grant register; resets to LSU so the IFU wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // Fixed priority: LSU over IFU.
  always_comb begin
    grant_lsu = arb_open && lsu_req_valid;
    grant_ifu = arb_open && ifu_req_valid && !lsu_req_valid;
  end
`endif

  // Next-state and request capture.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    w_data_d = w_data_q;
    mask_d   = mask_q;
    r_en_d   = r_en_q;
    w_en_d   = w_en_q;
    case (state_q)
      IDLE: begin
        if (grant_lsu) begin
          state_d  = REQ;
          owner_d  = OWNER_LSU;
          addr_d   = lsu_addr;
          w_data_d = lsu_w_data;
          mask_d   = lsu_mask;
          r_en_d   = !lsu_w_en;
          w_en_d   = lsu_w_en;
        end else if (grant_ifu) begin
          state_d  = REQ;
          owner_d  = OWNER_IFU;
          addr_d   = ifu_addr;
          w_data_d = '0;
          mask_d   = '1;
          r_en_d   = 1'b1;
          w_en_d   = 1'b0;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = RSP;
        end
      end
      RSP: begin
        if (mem_rsp_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured-request registers; reset drops any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWNER_IFU;
      addr_q   <= '0;
      w_data_q <= '0;
      mask_q   <= '0;
      r_en_q   <= 1'b0;
      w_en_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      w_data_q <= w_data_d;
      mask_q   <= mask_d;
      r_en_q   <= r_en_d;
      w_en_q   <= w_en_d;
    end
  end

  // Outputs: handshakes, memory request fields and response steering.
  always_comb begin
    ifu_req_ready = grant_ifu;
    lsu_req_ready = grant_lsu;
    mem_req_valid = (state_q == REQ);
    mem_addr      = addr_q;
    mem_w_data    = w_data_q;
    mem_mask      = mask_q;
    mem_r_en      = r_en_q && (state_q == REQ);
    mem_w_en      = w_en_q && (state_q == REQ);
    ifu_rsp_valid = (state_q == RSP) && (owner_q == OWNER_IFU) && mem_rsp_valid;
    lsu_rsp_valid = (state_q == RSP) && (owner_q == OWNER_LSU) && mem_rsp_valid;
    rsp_data      = mem_rsp_data;
  end

endmodule

// File: tb/tb_ysyx_23060075_mem_arbiter.sv
// Self-checking bench for ysyx_23060075_mem_arbiter: a cycle table from reset,
// hand-written stall / reset / tie sequences, then randomized traffic checked
// against a transaction-level model.
`timescale 1ns/1ps
module tb_ysyx_23060075_mem_arbiter;
  localparam int W = 32;
  localparam int M = 4;
`ifdef YSYX_23060075_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk, rst;
  logic ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [W-1:0] ifu_addr;
  logic lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_w_en;
  logic [W-1:0] lsu_addr, lsu_w_data, rsp_data;
  logic [M-1:0] lsu_mask, mem_mask;
  logic mem_req_valid, mem_req_ready, mem_r_en, mem_w_en, mem_rsp_valid;
  logic [W-1:0] mem_addr, mem_w_data, mem_rsp_data;

  ysyx_23060075_mem_arbiter #(.ISA_WIDTH(W), .MASK_WIDTH(M)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_rsp_valid(ifu_rsp_valid),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_w_data(lsu_w_data), .lsu_mask(lsu_mask),
    .lsu_w_en(lsu_w_en), .lsu_rsp_valid(lsu_rsp_valid), .rsp_data(rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_mask(mem_mask),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {ifu_rdy, lsu_rdy, mem_req_valid, mem_r_en, mem_w_en, ifu_rsp, lsu_rsp}
  function automatic logic [6:0] ctl();
    return {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_r_en, mem_w_en,
            ifu_rsp_valid, lsu_rsp_valid};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input bit lv, input bit mrdy, input bit mrv);
    ifu_req_valid = iv;
    lsu_req_valid = lv;
    mem_req_ready = mrdy;
    mem_rsp_valid = mrv;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference arbitration: returns {lsu_wins, ifu_wins}.
  function automatic logic [1:0] pick(input bit iv, input bit lv, input bit last_lsu);
    if (iv && lv && RR) return last_lsu ? 2'b01 : 2'b10;
    if (lv) return 2'b10;
    if (iv) return 2'b01;
    return 2'b00;
  endfunction

  typedef struct {
    logic iv, lv, mrdy, mrv;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[10];

  // Transaction-level model state for the random phase.
  bit busy, accepted, own_lsu, last_lsu;
  logic [W-1:0] e_addr, e_wd;
  logic [M-1:0] e_mask;
  bit e_r, e_w;

  initial begin
    logic [1:0] g;
    tbl[0] = '{1, 0, 0, 0, 7'b1000000};
    tbl[1] = '{0, 0, 1, 0, 7'b0011000};
    tbl[2] = '{0, 0, 0, 1, 7'b0000010};
    tbl[3] = '{0, 1, 0, 0, 7'b0100000};
    tbl[4] = '{0, 0, 1, 0, 7'b0010100};
    tbl[5] = '{0, 0, 0, 1, 7'b0000001};
    tbl[6] = '{0, 0, 0, 1, 7'b0000000};
    tbl[7] = '{1, 1, 0, 0, RR ? 7'b1000000 : 7'b0100000};
    tbl[8] = '{0, 0, 1, 0, RR ? 7'b0011000 : 7'b0010100};
    tbl[9] = '{0, 0, 0, 1, RR ? 7'b0000010 : 7'b0000001};

    // Reset state, with both requesters asking while rst is high.
    rst = 1'b1;
    drive(1, 1, 0, 0);
    ifu_addr = 32'h8000_0000;
    lsu_addr = 32'h8000_0104; lsu_w_data = 32'h00AB_0000;
    lsu_mask = 4'b0100;       lsu_w_en = 1'b1;
    mem_rsp_data = 32'h0000_0413;
    @(negedge clk);
    check("reset_ctl", ctl(), 7'b0);
    check("reset_fields", {mem_addr, mem_w_data[15:0], mem_mask}, '0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0);
    tick();

    // Cycle table: IFU fetch, LSU store, spurious response, tie.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].iv, tbl[i].lv, tbl[i].mrdy, tbl[i].mrv);
      @(negedge clk);
      check($sformatf("tbl_ctl[%0d]", i), ctl(), tbl[i].exp);
      if (tbl[i].exp[4] && tbl[i].exp[3])
        check($sformatf("tbl_ifu_fields[%0d]", i), {mem_addr, mem_w_data[27:0], mem_mask},
              {32'h8000_0000, 28'h0, 4'hF});
      if (tbl[i].exp[4] && tbl[i].exp[2])
        check($sformatf("tbl_lsu_fields[%0d]", i), {mem_addr, mem_w_data[27:0], mem_mask},
              {32'h8000_0104, 28'h0AB_0000, 4'b0100});
      if (tbl[i].exp[1] || tbl[i].exp[0])
        check($sformatf("tbl_rsp_data[%0d]", i), rsp_data, 32'h0000_0413);
      tick();
    end

    // Memory stalls 4 cycles; fields must hold even if the LSU inputs move.
    drive(1, 1, 0, 0);
    @(negedge clk);
    check("stall_grant", ctl(), 7'b0100000);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 0);
      lsu_addr = 32'hDEAD_BEE0; lsu_w_data = 32'h1111_1111; lsu_mask = 4'b1111;
      @(negedge clk);
      check($sformatf("stall_ctl[%0d]", k), ctl(), 7'b0010100);
      check($sformatf("stall_fields[%0d]", k), {mem_addr, mem_w_data[27:0], mem_mask},
            {32'h8000_0104, 28'h0AB_0000, 4'b0100});
      tick();
    end
    drive(1, 0, 1, 0);
    @(negedge clk);
    check("stall_accept", ctl(), 7'b0010100);
    tick();
    drive(0, 0, 0, 1);
    mem_rsp_data = 32'h0000_0000;
    @(negedge clk);
    check("stall_ack", ctl(), 7'b0000001);
    tick();

    // Reset pulsed while waiting in RSP; memory never answers.
    ifu_addr = 32'h8000_0020;
    drive(1, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0);
    tick();
    rst = 1'b1;
    drive(1, 1, 0, 0);
    @(negedge clk);
    check("rst_mid_ctl", ctl(), 7'b0);
    check("rst_mid_fields", {mem_addr, mem_w_data[15:0], mem_mask}, '0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0);
    @(negedge clk);
    check("post_rst_idle", ctl(), 7'b0);
    tick();
    ifu_addr = 32'h8000_0010;
    drive(1, 0, 0, 0);
    @(negedge clk);
    check("post_rst_grant", ctl(), 7'b1000000);
    tick();
    drive(0, 0, 1, 0);
    @(negedge clk);
    check("post_rst_addr", mem_addr, 32'h8000_0010);
    tick();
    mem_rsp_data = 32'h0000_1234;
    drive(0, 0, 0, 1);
    @(negedge clk);
    check("post_rst_rsp", {ctl(), rsp_data}, {7'b0000010, 32'h0000_1234});
    tick();

    // Both requesters valid for 6 back-to-back transactions.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, 0, 0);
      @(negedge clk);
      check($sformatf("tie_grant[%0d]", k), {ifu_req_ready, lsu_req_ready},
            (RR && (k % 2 == 0)) ? 2'b10 : 2'b01);
      tick();
      drive(1, 1, 1, 0);
      @(negedge clk);
      check($sformatf("tie_busy[%0d]", k), {ifu_req_ready, lsu_req_ready}, 2'b00);
      tick();
      drive(1, 1, 0, 1);
      tick();
    end

    // Randomized traffic against the transaction model.
    do_reset();
    busy = 0; accepted = 0; own_lsu = 0; last_lsu = 1;
    for (int c = 0; c < 3000; c++) begin
      ifu_addr     = $urandom & 32'hFFFF_FFFC;
      lsu_addr     = $urandom & 32'hFFFF_FFFC;
      lsu_w_data   = $urandom;
      lsu_mask     = 4'($urandom);
      lsu_w_en     = 1'($urandom);
      mem_rsp_data = $urandom;
      mem_req_ready = 1'($urandom);
      ifu_req_valid = 1'($urandom);
      lsu_req_valid = 1'($urandom);
      if (busy && accepted) mem_rsp_valid = ($urandom % 3) == 0;
      else if (!busy)       mem_rsp_valid = ($urandom % 5) == 0;
      else                  mem_rsp_valid = 1'b0;
      @(negedge clk);
      g = busy ? 2'b00 : pick(ifu_req_valid, lsu_req_valid, last_lsu);
      check("rand_ctl",
            {ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid},
            {g[0], g[1], busy && !accepted,
             busy && accepted && mem_rsp_valid && !own_lsu,
             busy && accepted && mem_rsp_valid && own_lsu});
      if (busy && !accepted) begin
        check("rand_addr", mem_addr, e_addr);
        check("rand_fields", {mem_w_data, mem_mask, mem_r_en, mem_w_en},
              {e_wd, e_mask, e_r, e_w});
      end
      if (busy && accepted && mem_rsp_valid)
        check("rand_rsp_data", rsp_data, mem_rsp_data);
      @(posedge clk);
      if (g != 2'b00) begin
        busy = 1; accepted = 0; own_lsu = g[1]; last_lsu = g[1];
        if (g[1]) begin
          e_addr = lsu_addr; e_wd = lsu_w_data; e_mask = lsu_mask;
          e_r = !lsu_w_en; e_w = lsu_w_en;
        end else begin
          e_addr = ifu_addr; e_wd = '0; e_mask = 4'hF; e_r = 1; e_w = 0;
        end
      end else if (busy && !accepted && mem_req_ready) begin
        accepted = 1;
      end else if (busy && accepted && mem_rsp_valid) begin
        busy = 0;
      end
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
